// File: rtl/fix_session_arbiter_if.sv
// Bundle of session-side and parser-side signals for the FIX session arbiter.
// The arbiter connects through the slave modport; the driving environment
// uses the master modport.
interface fix_session_arbiter_if #(
  parameter int NUM_SESS = 4,
  parameter int SID_W    = 2
);
  logic [NUM_SESS-1:0]    req_valid_i;
  logic [32*NUM_SESS-1:0] req_data_i;
  logic [NUM_SESS-1:0]    req_last_i;
  logic [NUM_SESS-1:0]    req_ready_o;
  logic [31:0]            data_o;
  logic                   data_valid_o;
  logic                   parser_ready_i;
  logic [SID_W-1:0]       sid_o;
  logic                   busy_o;
  logic                   abort_o;

  modport master (
    output req_valid_i, req_data_i, req_last_i, parser_ready_i,
    input  req_ready_o, data_o, data_valid_o, sid_o, busy_o, abort_o
  );

  modport slave (
    input  req_valid_i, req_data_i, req_last_i, parser_ready_i,
    output req_ready_o, data_o, data_valid_o, sid_o, busy_o, abort_o
  );
endinterface

// File: rtl/fix_session_arbiter.sv
// Shares a single FIX parser between NUM_SESS session streams. A session is
// granted for a whole message; grants rotate round-robin between messages.
// A stall watchdog aborts a granted session that stops supplying words and
// then drains (discards) the remainder of that message.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no grant; pick next requester searching upward from rr_ptr
//   ST_BUSY  | granted session's words pass through to the parser
//   ST_DRAIN | after an abort, granted session's words are accepted and
//            | dropped until its last word or a second stall timeout
module fix_session_arbiter #(
  parameter int NUM_SESS = 4,
  parameter int SID_W    = 2,
  parameter int TIMEOUT  = 16
) (
  input logic                  clk,
  input logic                  rst,
  fix_session_arbiter_if.slave bus
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(TIMEOUT - 1);
  localparam logic [SID_W-1:0] LAST_SID = SID_W'(NUM_SESS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SID_W-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             sel_valid;
  logic             sel_last;
  logic [31:0]      sel_data;
  logic             any_req;
  logic [SID_W-1:0] pick;
  logic [SID_W-1:0] gnt_nxt;
  logic             in_busy;
  logic             in_drain;
  logic             handshake;
  logic             cnt_tc;

  // Mux the granted session's valid/last/data onto a single lane.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NUM_SESS; k++) begin
      if (gnt_q == SID_W'(k)) begin
        sel_valid = bus.req_valid_i[k];
        sel_last  = bus.req_last_i[k];
        sel_data  = bus.req_data_i[32*k +: 32];
      end
    end
  end

  // Round-robin pick: walk downward so the lowest offset from rr_ptr wins.
  always_comb begin
    any_req = |bus.req_valid_i;
    pick    = '0;
    for (int i = NUM_SESS - 1; i >= 0; i--) begin
      int idx;
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_SESS) idx = idx - NUM_SESS;
      if (bus.req_valid_i[idx]) pick = SID_W'(idx);
    end
  end

  // Status decode shared by the outputs and the next-state logic.
  always_comb begin
    in_busy   = (state_q == ST_BUSY);
    in_drain  = (state_q == ST_DRAIN);
    handshake = in_busy & sel_valid & bus.parser_ready_i;
    cnt_tc    = (stall_cnt_q == CNT_TC);
    gnt_nxt   = (gnt_q == LAST_SID) ? '0 : gnt_q + SID_W'(1);
  end

  // Parser-side and session-side outputs; everything is quiet outside BUSY
  // except the drain-mode ready to the aborted session.
  always_comb begin
    bus.data_o       = in_busy ? sel_data : '0;
    bus.data_valid_o = in_busy & sel_valid;
    bus.sid_o        = in_busy ? gnt_q : '0;
    bus.busy_o       = in_busy;
    // A last-word handshake in the expiry cycle is a normal completion.
    bus.abort_o      = in_busy & ~handshake & cnt_tc;
    bus.req_ready_o  = '0;
    for (int k = 0; k < NUM_SESS; k++) begin
      if (gnt_q == SID_W'(k))
        bus.req_ready_o[k] = (in_busy & bus.parser_ready_i) | in_drain;
    end
  end

  // Next-state, grant, round-robin pointer and stall watchdog.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    stall_cnt_d = stall_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        stall_cnt_d = '0;
        if (any_req) begin
          gnt_d   = pick;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (handshake) begin
          stall_cnt_d = '0;
          if (sel_last) begin
            state_d  = ST_IDLE;
            rr_ptr_d = gnt_nxt;
          end
        end else if (cnt_tc) begin
          stall_cnt_d = '0;
          state_d     = ST_DRAIN;
          rr_ptr_d    = gnt_nxt;
        end else begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (sel_valid) begin
          stall_cnt_d = '0;
          if (sel_last) state_d = ST_IDLE;
        end else if (cnt_tc) begin
          stall_cnt_d = '0;
          state_d     = ST_IDLE;
        end else begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        stall_cnt_d = '0;
      end
    endcase
  end

  // State registers; synchronous active-low reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_fix_session_arbiter.sv
// Directed bench for fix_session_arbiter: single session, round-robin,
// backpressure, watchdog abort with drain, expiry tie and mid-message reset.
module tb_fix_session_arbiter;
  localparam int NUM_SESS = 4;
  localparam int SID_W    = 2;
  localparam int TIMEOUT  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total  = 0;
  int   passes = 0;

  fix_session_arbiter_if #(.NUM_SESS(NUM_SESS), .SID_W(SID_W)) bus ();

  fix_session_arbiter #(
    .NUM_SESS(NUM_SESS), .SID_W(SID_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drv(input int k, input logic v, input logic [31:0] d, input logic l);
    bus.req_valid_i[k]         = v;
    bus.req_data_i[32*k +: 32] = d;
    bus.req_last_i[k]          = l;
  endtask

  initial begin
    bus.req_valid_i    = '0;
    bus.req_data_i     = '0;
    bus.req_last_i     = '0;
    bus.parser_ready_i = 1'b0;

    // Reset
    cyc();
    cyc();
    settle();
    chk("rst_busy",   32'(bus.busy_o), 0);
    chk("rst_dv",     32'(bus.data_valid_o), 0);
    chk("rst_ready",  32'(bus.req_ready_o), 0);
    chk("rst_abort",  32'(bus.abort_o), 0);
    chk("rst_rr_ptr", 32'(dut.rr_ptr_q), 0);
    rst = 1'b1;

    // Single session 1, three words
    cyc();
    bus.parser_ready_i = 1'b1;
    drv(1, 1'b1, 32'h0132323D, 1'b0);
    settle();
    chk("t1_idle_busy",  32'(bus.busy_o), 0);
    chk("t1_idle_ready", 32'(bus.req_ready_o), 0);
    cyc();
    settle();
    chk("t1_busy",   32'(bus.busy_o), 1);
    chk("t1_sid",    32'(bus.sid_o), 1);
    chk("t1_w0",     bus.data_o, 32'h0132323D);
    chk("t1_dv0",    32'(bus.data_valid_o), 1);
    chk("t1_ready",  32'(bus.req_ready_o), 32'h2);
    cyc();
    drv(1, 1'b1, 32'h33330132, 1'b0);
    settle();
    chk("t1_w1",     bus.data_o, 32'h33330132);
    cyc();
    drv(1, 1'b1, 32'h39323336, 1'b1);
    settle();
    chk("t1_w2",     bus.data_o, 32'h39323336);
    chk("t1_sid2",   32'(bus.sid_o), 1);
    cyc();
    drv(1, 1'b0, 32'h0, 1'b0);
    settle();
    chk("t1_end_busy", 32'(bus.busy_o), 0);
    chk("t1_rr_ptr",   32'(dut.rr_ptr_q), 2);

    // Reset back to rr_ptr=0, then round-robin between sessions 0 and 2
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    drv(0, 1'b1, 32'hA0A0A0A0, 1'b0);
    drv(2, 1'b1, 32'hC0C0C0C0, 1'b0);
    settle();
    chk("t2_rr_ptr0", 32'(dut.rr_ptr_q), 0);
    cyc();
    settle();
    chk("t2_sid0",    32'(bus.sid_o), 0);
    chk("t2_a0",      bus.data_o, 32'hA0A0A0A0);
    chk("t2_ready0",  32'(bus.req_ready_o), 32'h1);
    cyc();
    drv(0, 1'b1, 32'hA1A1A1A1, 1'b1);
    settle();
    chk("t2_a1",      bus.data_o, 32'hA1A1A1A1);
    chk("t2_sid0b",   32'(bus.sid_o), 0);
    cyc();
    drv(0, 1'b0, 32'h0, 1'b0);
    settle();
    chk("t2_gap_busy",  32'(bus.busy_o), 0);
    chk("t2_gap_ready", 32'(bus.req_ready_o), 0);
    cyc();
    settle();
    chk("t2_sid2",    32'(bus.sid_o), 2);
    chk("t2_c0",      bus.data_o, 32'hC0C0C0C0);
    chk("t2_ready2",  32'(bus.req_ready_o), 32'h4);
    cyc();
    drv(2, 1'b1, 32'hC1C1C1C1, 1'b1);
    settle();
    chk("t2_c1",      bus.data_o, 32'hC1C1C1C1);
    cyc();
    drv(2, 1'b0, 32'h0, 1'b0);
    settle();
    chk("t2_end_busy", 32'(bus.busy_o), 0);
    chk("t2_rr_ptr",   32'(dut.rr_ptr_q), 3);

    // Backpressure on session 3: parser_ready 1,0,0,1 then 1
    drv(3, 1'b1, 32'hD0D0D0D0, 1'b0);
    cyc();
    settle();
    chk("t3_sid",     32'(bus.sid_o), 3);
    chk("t3_d0",      bus.data_o, 32'hD0D0D0D0);
    chk("t3_rdy_a",   32'(bus.req_ready_o), 32'h8);
    cyc();
    drv(3, 1'b1, 32'hD1D1D1D1, 1'b0);
    bus.parser_ready_i = 1'b0;
    settle();
    chk("t3_d1_hold", bus.data_o, 32'hD1D1D1D1);
    chk("t3_rdy_b",   32'(bus.req_ready_o), 0);
    chk("t3_dv_b",    32'(bus.data_valid_o), 1);
    cyc();
    settle();
    chk("t3_rdy_c",   32'(bus.req_ready_o), 0);
    chk("t3_abort_c", 32'(bus.abort_o), 0);
    cyc();
    bus.parser_ready_i = 1'b1;
    settle();
    chk("t3_d1",      bus.data_o, 32'hD1D1D1D1);
    chk("t3_rdy_d",   32'(bus.req_ready_o), 32'h8);
    cyc();
    drv(3, 1'b1, 32'hD2D2D2D2, 1'b1);
    settle();
    chk("t3_d2",      bus.data_o, 32'hD2D2D2D2);
    chk("t3_abort_e", 32'(bus.abort_o), 0);
    cyc();
    drv(3, 1'b0, 32'h0, 1'b0);
    settle();
    chk("t3_end_busy", 32'(bus.busy_o), 0);
    chk("t3_rr_ptr",   32'(dut.rr_ptr_q), 0);

    // Watchdog: session 0 sends one word then stalls for 16 cycles
    drv(0, 1'b1, 32'hE0E0E0E0, 1'b0);
    cyc();
    settle();
    chk("t4_sid",     32'(bus.sid_o), 0);
    chk("t4_w0",      bus.data_o, 32'hE0E0E0E0);
    cyc();
    drv(0, 1'b0, 32'h0, 1'b0);
    for (int s = 1; s < TIMEOUT; s++) begin
      settle();
      chk($sformatf("t4_stall%0d_abort", s), 32'(bus.abort_o), 0);
      cyc();
    end
    settle();
    chk("t4_abort",      32'(bus.abort_o), 1);
    chk("t4_abort_busy", 32'(bus.busy_o), 1);
    cyc();
    drv(0, 1'b1, 32'hE1E1E1E1, 1'b0);
    settle();
    chk("t4_drain_busy", 32'(bus.busy_o), 0);
    chk("t4_drain_dv0",  32'(bus.data_valid_o), 0);
    chk("t4_drain_rdy0", 32'(bus.req_ready_o), 32'h1);
    chk("t4_drain_ab0",  32'(bus.abort_o), 0);
    cyc();
    drv(0, 1'b1, 32'hE2E2E2E2, 1'b1);
    settle();
    chk("t4_drain_dv1",  32'(bus.data_valid_o), 0);
    chk("t4_drain_rdy1", 32'(bus.req_ready_o), 32'h1);
    cyc();
    drv(0, 1'b0, 32'h0, 1'b0);
    settle();
    chk("t4_idle_rdy",   32'(bus.req_ready_o), 0);
    chk("t4_rr_ptr",     32'(dut.rr_ptr_q), 1);

    // Expiry tie: last-word handshake exactly when stall_cnt == TIMEOUT-1
    drv(1, 1'b1, 32'hF0F0F0F0, 1'b0);
    cyc();
    settle();
    chk("t5_sid",     32'(bus.sid_o), 1);
    chk("t5_w0",      bus.data_o, 32'hF0F0F0F0);
    cyc();
    drv(1, 1'b0, 32'h0, 1'b0);
    for (int s = 1; s < TIMEOUT; s++) begin
      settle();
      chk($sformatf("t5_stall%0d_abort", s), 32'(bus.abort_o), 0);
      cyc();
    end
    drv(1, 1'b1, 32'hF1F1F1F1, 1'b1);
    settle();
    chk("t5_tie_abort", 32'(bus.abort_o), 0);
    chk("t5_tie_dv",    32'(bus.data_valid_o), 1);
    chk("t5_tie_data",  bus.data_o, 32'hF1F1F1F1);
    cyc();
    drv(1, 1'b0, 32'h0, 1'b0);
    settle();
    chk("t5_end_busy", 32'(bus.busy_o), 0);
    chk("t5_rr_ptr",   32'(dut.rr_ptr_q), 2);

    // Mid-message reset during BUSY on session 2
    drv(2, 1'b1, 32'h12345678, 1'b0);
    cyc();
    settle();
    chk("t6_busy",    32'(bus.busy_o), 1);
    chk("t6_sid",     32'(bus.sid_o), 2);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    settle();
    chk("t6_busy_after",  32'(bus.busy_o), 0);
    chk("t6_dv_after",    32'(bus.data_valid_o), 0);
    chk("t6_data_after",  bus.data_o, 0);
    chk("t6_rdy_after",   32'(bus.req_ready_o), 0);
    chk("t6_sid_after",   32'(bus.sid_o), 0);
    chk("t6_abort_after", 32'(bus.abort_o), 0);
    chk("t6_rr_ptr",      32'(dut.rr_ptr_q), 0);
    drv(2, 1'b0, 32'h0, 1'b0);
    cyc();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/fix_session_arbiter.md
Name: fix_session_arbiter

Overview:
- Shares one fix_parser_top instance between NUM_SESS independent FIX session input streams.
- Each stream delivers raw FIX bytes packed 4 per 32-bit word, with a last flag on the final word of each message.
- The arbiter grants the parser to one session for a whole message, rotating round-robin between messages.
- A stall watchdog aborts a granted session that stops supplying words mid-message, then drains and discards the rest of that message.

Parameters:
- NUM_SESS, 4, number of requesting sessions (2..8).
- SID_W, 2, width of the session id; must satisfy 2^SID_W >= NUM_SESS.
- TIMEOUT, 16, number of consecutive no-handshake cycles in BUSY or DRAIN before the watchdog fires (>= 2).

Ports:
- clk, in, 1, single clock; all logic on the rising edge.
- rst, in, 1, synchronous, active-low reset.
- req_valid_i, in, NUM_SESS, per-session word valid.
- req_data_i, in, 32*NUM_SESS, per-session word; session k occupies bits [32k+31:32k].
- req_last_i, in, NUM_SESS, per-session end-of-message flag, qualified by valid.
- req_ready_o, out, NUM_SESS, per-session word accepted.
- data_o, out, 32, word to the parser data_i.
- data_valid_o, out, 1, data_o valid.
- parser_ready_i, in, 1, parser can accept a word this cycle.
- sid_o, out, SID_W, session currently granted; meaningful only in BUSY.
- busy_o, out, 1, high in BUSY.
- abort_o, out, 1, one-cycle pulse when the watchdog fires in BUSY.

Behaviour:
- Reset (rst==0 at a posedge):
  - state=IDLE, rr_ptr=0, gnt=0, stall_cnt=0.
  - All outputs 0; req_ready_o=0.
  - Reset takes priority over every other event, including mid-message. No abort_o pulse is produced and there is no drain.
- States: IDLE, BUSY, DRAIN.
- IDLE:
  - Outputs idle; req_ready_o all 0.
  - If any req_valid_i bit is set, gnt <= first index with valid, searching from rr_ptr upward and wrapping modulo NUM_SESS. Next state is BUSY.
  - Arbitration latency: 1 cycle. The request is sampled in IDLE; data flows from the next cycle.
  - If no valid bit is set, remain in IDLE.
- BUSY (combinational path from the granted session):
  - data_o = req_data_i[gnt].
  - data_valid_o = req_valid_i[gnt].
  - req_ready_o[gnt] = parser_ready_i; all other ready bits are 0.
  - sid_o = gnt; busy_o = 1.
  - Handshake = req_valid_i[gnt] & parser_ready_i.
  - Handshake with last: next state IDLE, rr_ptr <= (gnt+1) mod NUM_SESS, stall_cnt <= 0.
  - Handshake without last: stall_cnt <= 0.
  - No handshake: stall_cnt <= stall_cnt+1.
  - When stall_cnt == TIMEOUT-1 and there is no handshake:
    - abort_o = 1 in that cycle.
    - Next state DRAIN; stall_cnt <= 0.
    - rr_ptr <= (gnt+1) mod NUM_SESS.
  - Parser backpressure (parser_ready_i=0) counts as a stall. TIMEOUT must be sized above the parser's worst-case backpressure.
- DRAIN:
  - data_valid_o = 0.
  - req_ready_o[gnt] = 1 unconditionally; words are discarded.
  - Valid word with last: next state IDLE.
  - Valid word without last: stall_cnt <= 0.
  - No valid word: stall_cnt increments; reaching TIMEOUT-1 → IDLE silently, with no second abort.
- Simultaneous events: a handshake on a last word in the cycle the counter would expire counts as a normal completion, not an abort.
- Non-granted sessions may hold valid indefinitely. Their data is never forwarded and never dropped.
- Invariants:
  - A message is never interleaved with another session's words at data_o.
  - sid_o is stable for the whole of BUSY.
  - Back-to-back messages from the same session are allowed only if no other session is requesting.

Test Plan:
- Reset then single session: session 1 sends 0x0132323D, 0x33330132, 0x39323336 (last), parser_ready=1. Required: grant one cycle after valid; sid_o=1; three words appear on data_o in order on consecutive cycles; then IDLE; rr_ptr=2.
- Round-robin: sessions 0 and 2 each hold a 2-word message valid from the same cycle, rr_ptr=0. Required: session 0's message completes, then session 2's; no interleaving; rr_ptr=3 at the end.
- Backpressure: session 3 message, parser_ready_i toggling 1,0,0,1. Required: req_ready_o[3] mirrors parser_ready_i; no word is duplicated or lost; no abort for stalls < TIMEOUT.
- Watchdog: session 0 sends 1 word, then drops valid for 16 cycles. Required: abort_o pulses in the 16th stall cycle. DRAIN then discards 2 words (the second with last); nothing appears on data_valid_o; then IDLE with rr_ptr=1.
- Expiry tie: last-word handshake lands exactly in the cycle stall_cnt==TIMEOUT-1. Required: no abort_o; normal return to IDLE.
- Mid-message reset: rst=0 for one cycle during BUSY. Required: all outputs 0 on the next cycle; state IDLE; rr_ptr=0; no abort_o.
